// File: rtl/ps2_pad_move_ctrl.sv
// ps2_pad_move_ctrl: turns latched PS/2 pad button samples into a sprite
// position (x_move, y_move) that updates once per video frame on the v_sync
// falling edge, with hold-to-accelerate, screen clamping, START recentre and
// a stale-input timeout.
module ps2_pad_move_ctrl #(
    parameter int X_MAX          = 576,
    parameter int Y_MAX          = 416,
    parameter int X_INIT         = 288,
    parameter int Y_INIT         = 208,
    parameter int STEP_SLOW      = 1,
    parameter int STEP_FAST      = 4,
    parameter int ACCEL_FRAMES   = 30,
    parameter int TIMEOUT_FRAMES = 8
) (
    input  logic        sclk,
    input  logic        rst_n,
    input  logic        btn_valid,
    input  logic [15:0] btn_data,
    input  logic        v_sync,
    output logic [9:0]  x_move,
    output logic [9:0]  y_move,
    output logic        moving
);

    localparam int AW = $clog2(ACCEL_FRAMES + 1);
    localparam int TW = $clog2(TIMEOUT_FRAMES + 1);

    localparam logic signed [10:0] X_MAX_S = 11'(X_MAX);
    localparam logic signed [10:0] Y_MAX_S = 11'(Y_MAX);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SLOW = 2'd1,
        FAST = 2'd2
    } state_t;

    state_t        state, state_nxt;
    logic [15:0]   btn_latch, latch_nxt;
    logic          v_sync_d;
    logic          frame_tick;
    logic [AW-1:0] accel_cnt, accel_nxt;
    logic [TW-1:0] tmo_cnt, tmo_nxt;
    logic          release_now;
    logic [15:0]   pos_btn;
    logic          fsm_dx, fsm_dy, fsm_any;
    logic          p_up, p_down, p_left, p_right, p_start;
    logic signed [10:0] step_s, x_ext, y_ext;
    logic [9:0]    x_nxt, y_nxt;

    // Clamp an 11-bit signed candidate position into [0, maxv].
    function automatic logic [9:0] clamp(input logic signed [10:0] v,
                                         input logic signed [10:0] maxv);
        if (v < 0)
            return '0;
        else if (v > maxv)
            return maxv[9:0];
        else
            return v[9:0];
    endfunction

    assign frame_tick = v_sync_d & ~v_sync;

    // Button latch and stale-input timeout; a fresh sample always wins.
    always_comb begin
        latch_nxt   = btn_latch;
        tmo_nxt     = tmo_cnt;
        release_now = 1'b0;
        if (btn_valid) begin
            latch_nxt = btn_data;
            tmo_nxt   = '0;
        end else if (frame_tick && (tmo_cnt < TW'(TIMEOUT_FRAMES))) begin
            tmo_nxt = tmo_cnt + 1'b1;
        end
        if (frame_tick && !btn_valid && (tmo_nxt == TW'(TIMEOUT_FRAMES))) begin
            release_now = 1'b1;
            latch_nxt   = '1;
        end
    end

    // The forced release freezes the position on the frame the timeout is
    // reached; the speed FSM only sees the released latch on the next frame.
    assign pos_btn = release_now ? 16'hFFFF : btn_latch;

    // Direction decode (active-low buttons): FSM view and position view.
    always_comb begin
        fsm_dx  = btn_latch[7] ^ btn_latch[5];
        fsm_dy  = btn_latch[4] ^ btn_latch[6];
        fsm_any = fsm_dx | fsm_dy;
        p_start = ~pos_btn[3];
        p_up    = ~pos_btn[4] &  pos_btn[6];
        p_down  = ~pos_btn[6] &  pos_btn[4];
        p_right = ~pos_btn[5] &  pos_btn[7];
        p_left  = ~pos_btn[7] &  pos_btn[5];
    end

    // Speed FSM next state and acceleration counter, evaluated per frame.
    always_comb begin
        state_nxt = state;
        accel_nxt = accel_cnt;
        if (frame_tick) begin
            if (p_start) begin
                state_nxt = IDLE;
                accel_nxt = '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (fsm_any) begin
                            state_nxt = SLOW;
                            accel_nxt = '0;
                        end
                    end
                    SLOW: begin
                        if (!fsm_any) begin
                            state_nxt = IDLE;
                        end else begin
                            accel_nxt = accel_cnt + 1'b1;
                            if (accel_nxt == AW'(ACCEL_FRAMES - 1))
                                state_nxt = FAST;
                        end
                    end
                    FAST: begin
                        if (!fsm_any)
                            state_nxt = IDLE;
                    end
                    default: state_nxt = IDLE;
                endcase
            end
        end
    end

    // Next position: step by current speed, clamp to screen, START recentres.
    always_comb begin
        step_s = (state == FAST) ? 11'(STEP_FAST) : 11'(STEP_SLOW);
        x_ext  = signed'({1'b0, x_move});
        y_ext  = signed'({1'b0, y_move});
        x_nxt  = x_move;
        y_nxt  = y_move;
        if (frame_tick) begin
            if (p_start) begin
                x_nxt = 10'(X_INIT);
                y_nxt = 10'(Y_INIT);
            end else begin
                if (p_right)
                    x_nxt = clamp(x_ext + step_s, X_MAX_S);
                else if (p_left)
                    x_nxt = clamp(x_ext - step_s, X_MAX_S);
                if (p_down)
                    y_nxt = clamp(y_ext + step_s, Y_MAX_S);
                else if (p_up)
                    y_nxt = clamp(y_ext - step_s, Y_MAX_S);
            end
        end
    end

    // State register for FSM, counters, latch and sync edge detector.
    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            accel_cnt <= '0;
            tmo_cnt   <= '0;
            btn_latch <= 16'hFFFF;
            v_sync_d  <= 1'b1;
        end else begin
            state     <= state_nxt;
            accel_cnt <= accel_nxt;
            tmo_cnt   <= tmo_nxt;
            btn_latch <= latch_nxt;
            v_sync_d  <= v_sync;
        end
    end

    // Registered outputs.
    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            x_move <= 10'(X_INIT);
            y_move <= 10'(Y_INIT);
            moving <= 1'b0;
        end else begin
            x_move <= x_nxt;
            y_move <= y_nxt;
            moving <= (state_nxt != IDLE);
        end
    end

endmodule

// File: tb/tb_ps2_pad_move_ctrl.sv
// Directed testbench for ps2_pad_move_ctrl with hand-computed expectations.
module tb_ps2_pad_move_ctrl;

    logic        sclk = 1'b0;
    logic        rst_n;
    logic        btn_valid;
    logic [15:0] btn_data;
    logic        v_sync;
    logic [9:0]  x_move;
    logic [9:0]  y_move;
    logic        moving;

    int vectors     = 0;
    int miscompares = 0;

    localparam logic [15:0] REL   = 16'hFFFF;
    localparam logic [15:0] RIGHT = 16'hFFDF;
    localparam logic [15:0] LEFT  = 16'hFF7F;
    localparam logic [15:0] UP    = 16'hFFEF;
    localparam logic [15:0] LR    = 16'hFF5F;
    localparam logic [15:0] UL    = 16'hFF6F;
    localparam logic [15:0] STDN  = 16'hFFB7;

    ps2_pad_move_ctrl dut (
        .sclk      (sclk),
        .rst_n     (rst_n),
        .btn_valid (btn_valid),
        .btn_data  (btn_data),
        .v_sync    (v_sync),
        .x_move    (x_move),
        .y_move    (y_move),
        .moving    (moving)
    );

    always #5 sclk = ~sclk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_pos(input string tag, input int ex, input int ey, input logic em);
        chk({tag, ".x"}, {6'd0, x_move}, 16'(ex));
        chk({tag, ".y"}, {6'd0, y_move}, 16'(ey));
        chk({tag, ".moving"}, {15'd0, moving}, {15'd0, em});
    endtask

    // mode 0: no sample; 1: sample ahead of the frame tick; 2: sample on the tick edge.
    task automatic frame(input int mode, input logic [15:0] d);
        @(negedge sclk);
        if (mode == 1) begin
            btn_valid = 1'b1;
            btn_data  = d;
            @(negedge sclk);
            btn_valid = 1'b0;
        end
        repeat (2) @(negedge sclk);
        v_sync = 1'b0;
        if (mode == 2) begin
            btn_valid = 1'b1;
            btn_data  = d;
        end
        @(negedge sclk);
        btn_valid = 1'b0;
        repeat (2) @(negedge sclk);
        v_sync = 1'b1;
        @(negedge sclk);
    endtask

    initial begin
        rst_n     = 1'b0;
        btn_valid = 1'b0;
        btn_data  = 16'h0000;
        v_sync    = 1'b1;
        repeat (3) @(negedge sclk);
        chk_pos("in_reset", 288, 208, 1'b0);
        rst_n = 1'b1;
        @(negedge sclk);
        chk_pos("after_reset", 288, 208, 1'b0);

        // Idle frames with no samples: nothing moves.
        for (int i = 0; i < 3; i++) begin
            frame(0, REL);
            chk_pos("idle", 288, 208, 1'b0);
        end

        // RIGHT held: 30 slow frames then fast.
        for (int k = 1; k <= 32; k++) begin
            frame(1, RIGHT);
            chk_pos("right_hold", (k <= 30) ? 288 + k : 318 + 4 * (k - 30), 208, 1'b1);
        end
        frame(1, REL);
        chk_pos("right_release", 326, 208, 1'b0);

        // UP held down to the top edge, clamping from 2 to 0 in FAST.
        for (int k = 1; k <= 76; k++) begin
            frame(1, UP);
            if (k == 30) chk_pos("up_slow_end", 326, 178, 1'b1);
            if (k == 74) chk_pos("up_at_2", 326, 2, 1'b1);
            if (k == 75) chk_pos("up_clamp", 326, 0, 1'b1);
            if (k == 76) chk_pos("up_stay0", 326, 0, 1'b1);
        end

        // START with DOWN while FAST: recentre, FSM back to idle.
        frame(1, STDN);
        chk_pos("start", 288, 208, 1'b0);
        frame(1, REL);
        chk_pos("start_release", 288, 208, 1'b0);

        // Opposing LEFT+RIGHT: no motion, stays idle.
        for (int i = 0; i < 3; i++) begin
            frame(1, LR);
            chk_pos("left_right", 288, 208, 1'b0);
        end

        // Diagonal UP+LEFT.
        for (int k = 1; k <= 3; k++) begin
            frame(1, UL);
            chk_pos("diag", 288 - k, 208 - k, 1'b1);
        end
        frame(1, REL);
        chk_pos("diag_release", 285, 205, 1'b0);

        // Timeout: one RIGHT sample, then samples stop.
        frame(1, RIGHT);
        chk_pos("tmo_f1", 286, 205, 1'b1);
        for (int k = 2; k <= 7; k++) begin
            frame(0, REL);
            chk_pos("tmo_move", 285 + k, 205, 1'b1);
        end
        frame(0, REL);
        chk_pos("tmo_f8", 292, 205, 1'b1);
        frame(0, REL);
        chk_pos("tmo_f9", 292, 205, 1'b0);
        frame(0, REL);
        chk_pos("tmo_f10", 292, 205, 1'b0);

        // Sample coincident with frame tick: old latch drives this frame.
        frame(1, RIGHT);
        chk_pos("coin_pre", 293, 205, 1'b1);
        frame(2, LEFT);
        chk_pos("coin_tick", 294, 205, 1'b1);
        frame(0, REL);
        chk_pos("coin_next", 293, 205, 1'b1);
        frame(1, REL);
        chk_pos("coin_release", 293, 205, 1'b0);

        // RIGHT held to the right edge: 575 -> 576 clamp and hold.
        for (int k = 1; k <= 95; k++) begin
            frame(1, RIGHT);
            if (k == 30) chk_pos("rclamp_slow_end", 323, 205, 1'b1);
            if (k == 93) chk_pos("rclamp_575", 575, 205, 1'b1);
            if (k == 94) chk_pos("rclamp_576", 576, 205, 1'b1);
            if (k == 95) chk_pos("rclamp_stay", 576, 205, 1'b1);
        end

        // Reset mid-operation takes effect immediately.
        @(negedge sclk);
        rst_n = 1'b0;
        #1;
        chk_pos("mid_reset", 288, 208, 1'b0);
        @(negedge sclk);
        rst_n = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ps2_pad_move_ctrl.md
Name: ps2_pad_move_ctrl

Overview:
- Converts PS/2 (DualShock-style) controller button samples into the sprite position pair `x_move` / `y_move` consumed by the VGA timing/picture stage.
- Sits directly upstream of that stage, in the same `sclk` pixel-clock domain.
- Position updates once per video frame, on the `v_sync` falling edge, with hold-to-accelerate speed, screen clamping, recentre on START, and a stale-input timeout.

Parameters:
- X_MAX, 576: maximum `x_move` (inclusive); minimum is 0.
- Y_MAX, 416: maximum `y_move` (inclusive); minimum is 0.
- X_INIT, 288: `x_move` value after reset and on START.
- Y_INIT, 208: `y_move` value after reset and on START.
- STEP_SLOW, 1: pixels per frame in the SLOW state.
- STEP_FAST, 4: pixels per frame in the FAST state.
- ACCEL_FRAMES, 30: frames spent in SLOW before entering FAST.
- TIMEOUT_FRAMES, 8: frames without `btn_valid` before buttons are forced released.

Ports:
- sclk  in  1  pixel clock; the only clock.
- rst_n  in  1  reset; asynchronous assert, active-low.
- btn_valid  in  1  one-cycle strobe: `btn_data` holds a new controller sample.
- btn_data  in  16  active-low buttons. [7:0] = byte3 (bit3 START, bit4 UP, bit5 RIGHT, bit6 DOWN, bit7 LEFT); [15:8] = byte4, ignored.
- v_sync  in  1  active-low vertical sync from the timing stage.
- x_move  out  10  sprite X position, registered.
- y_move  out  10  sprite Y position, registered.
- moving  out  1  high while the speed FSM is not IDLE.

Behaviour:
- Reset values:
  - `x_move` = X_INIT; `y_move` = Y_INIT; `moving` = 0.
  - Button latch = 16'hFFFF (all released).
  - `v_sync_d` = 1; FSM = IDLE; accel counter = 0; timeout counter = 0.
  - Reset mid-operation aborts everything immediately to these values.
- Button latch:
  - On `btn_valid` = 1, the latch loads `btn_data` and the timeout counter clears.
  - Otherwise the latch holds.
- Frame tick:
  - `v_sync_d` registers `v_sync`; `frame_tick` = `v_sync_d` & ~`v_sync`.
  - All position, FSM and timeout updates occur on the `sclk` edge where `frame_tick` = 1. Result is visible one cycle after `v_sync` is first sampled low.
  - Exactly one update per frame.
- Timeout:
  - On each `frame_tick` without `btn_valid`, the counter increments, saturating at TIMEOUT_FRAMES.
  - When it reaches TIMEOUT_FRAMES, the latch is forced to 16'hFFFF.
  - `btn_valid` in the same cycle wins: latch loads, counter clears.
- Same-cycle `btn_valid` and `frame_tick`: the frame update uses the latch value from before this edge; the new sample affects the next frame.
- Decoded directions (from the latch, active-low):
  - `up` = ~L[4], `right` = ~L[5], `down` = ~L[6], `left` = ~L[7], `start` = ~L[3].
  - `dx_active` = `left` XOR `right`; `dy_active` = `up` XOR `down`. Opposing pair pressed means no motion on that axis.
  - `any_dir` = `dx_active` | `dy_active`.
- Speed FSM, evaluated on `frame_tick`:
  - IDLE: if `any_dir`, go to SLOW, clear accel counter, apply STEP_SLOW this frame.
  - SLOW: if not `any_dir`, go to IDLE. Else increment counter; when counter = ACCEL_FRAMES-1, go to FAST. This frame uses STEP_SLOW.
  - FAST: if not `any_dir`, go to IDLE; else stay and use STEP_FAST.
  - A direction change while held does not reset speed.
- START:
  - On a `frame_tick` with `start` = 1: `x_move` = X_INIT, `y_move` = Y_INIT, FSM = IDLE, counter = 0.
  - START has priority over movement that frame.
- Position arithmetic (11-bit signed intermediate):
  - `right`: x+step; `left`: x−step; `down`: y+step; `up`: y−step.
  - Results below 0 clamp to 0; above X_MAX / Y_MAX clamp to the maximum.
  - No wrap-around.
  - X and Y move independently, so diagonals are permitted.
- `moving`: registered, equals (FSM ≠ IDLE).

Test Plan:
- Reset, then release: `x_move` = 288, `y_move` = 208, `moving` = 0. No change over 3 frames with no `btn_valid`.
- RIGHT held (`btn_data` = 16'hFFDF, `btn_valid` every frame) for 32 frames:
  - frames 1–30 each +1, giving x = 318 after frame 30;
  - frames 31–32 +4, giving x = 326;
  - `moving` = 1 from frame 1.
- Clamp: UP held from y = 2 in FAST → y = 0 and stays 0. RIGHT from x = 575 → 576 and stays 576.
- LEFT + RIGHT held (16'hFF5F) → x unchanged, FSM stays IDLE, `moving` = 0. UP + LEFT (16'hFF6F) → x−1 and y−1 per frame.
- START (16'hFFF7) together with DOWN, in FAST at (100, 50) → next frame (288, 208), FSM IDLE.
- Timeout: RIGHT latched, then `btn_valid` stops → x increments for frames 1–7 and frames 8+ are frozen. Frame 8: the counter reaches 8, the latch is forced released, no move. `moving` falls after frame 9.
- `btn_valid` coincident with `frame_tick` changing RIGHT to LEFT → that frame still moves +step, the following frame moves −step.
